fft_ctrl: RTL
=============

FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning FFT length (power of two, 4 to 1024).
REQ-002 The block SHALL have parameter LAT, default 2, meaning butterfly pipeline latency in cycles (0 to 8).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock (rising edge).
REQ-004 The block SHALL have port rst, input, 1 bit, meaning the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port i_start, input, 1 bit, meaning start a load-then-compute run.
REQ-006 The block SHALL have ports i_load_valid (input, 1) and o_load_ready (output, 1), meaning the sample-load handshake.
REQ-007 The block SHALL have ports o_load_wr_en (output, 1) and o_load_addr (output, $clog2(N)), meaning the RAM1 load write strobe and its bit-reversed address.
REQ-008 The block SHALL have ports o_rd_en (output, 1), o_rd_addr (output, $clog2(N)) and o_rd_odd (output, 1), meaning the read strobe, the read address and the even/odd demux select.
REQ-009 The block SHALL have ports o_rd_sel (output, 1) and o_twi_addr (output, $clog2(N)-1), meaning read-RAM select (0=RAM1, 1=RAM2) and twiddle ROM index.
REQ-010 The block SHALL have ports o_wr_en (output, 1), o_wr_addr (output, $clog2(N)) and o_wr_bot (output, 1), meaning the write-back strobe, its address and the top/bottom mux select.
REQ-011 The block SHALL have ports o_stage (output, $clog2($clog2(N))), o_busy (output, 1), o_done (output, 1) and o_result_sel (output, 1).

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, READ, DRAIN and DONE.
REQ-013 In IDLE, i_start=1 SHALL move the FSM to LOAD; i_start SHALL be ignored in every other state.
REQ-014 In LOAD, o_load_ready=1, and each cycle with i_load_valid=1 SHALL assert o_load_wr_en with o_load_addr=bitrev(count) and increment count; after the Nth sample the FSM SHALL enter READ with stage 0.
REQ-015 For stage s, half=2^s, butterfly j from 0 to N/2-1, with pos=j mod half: a=(j>>s)*2*half+pos, b=a+half, k=pos<<(log2N-1-s).
REQ-016 READ SHALL spend 2 cycles per butterfly: cycle t drives o_rd_addr=a, o_rd_odd=0, o_twi_addr=k; cycle t+1 drives o_rd_addr=b, o_rd_odd=1; o_rd_en=1 in both cycles.
REQ-017 The write-back of a butterfly SHALL be o_wr_en=1, o_wr_bot=0, o_wr_addr=a at cycle t+1+LAT, and o_wr_bot=1, o_wr_addr=b at cycle t+2+LAT.
REQ-018 o_rd_sel SHALL equal s mod 2, and writes SHALL target the other RAM.
REQ-019 After the last read of a stage, the FSM SHALL enter DRAIN; the next stage's first read SHALL occur the cycle after that stage's last write, so each stage takes N+LAT+1 cycles.
REQ-020 After the final stage drains, the FSM SHALL spend one cycle in DONE with o_done=1, then return to IDLE.
REQ-021 o_result_sel SHALL equal log2N mod 2, and SHALL be held from DONE until the next i_start.
REQ-022 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-023 rst=0 SHALL asynchronously force IDLE, clear all counters and the write delay line, and drive every output to 0, including during a run in progress.
REQ-024 After reset release, no write strobe from an aborted run SHALL appear.

Configuration
REQ-025 When FFT_CTRL_INVERSE_EN is defined, the block SHALL have input i_inverse and output o_twi_conj, where o_twi_conj equals i_inverse sampled at i_start and is held until the run ends.
REQ-026 When FFT_CTRL_INVERSE_EN is not defined, neither port SHALL exist and the block SHALL compute forward transforms only.

Structure
REQ-027 Package fft_pkg SHALL hold the FSM state enum, the LOG2N/stage-width constants and a bitrev function.
REQ-028 Sub-module fft_wb_delay SHALL implement the LAT+1-deep delay line of {valid, addr, bot}.

Verification
REQ-029 With N=8 and 8 valid loads, o_load_addr SHALL be 0,4,2,6,1,5,3,7, followed by READ.
REQ-030 In stage 0, the reads SHALL be (0,1,k0),(2,3,k0),(4,5,k0),(6,7,k0) with o_rd_sel=0 and the writes going to RAM2.
REQ-031 In stage 1, butterfly j=1 SHALL read a=1, b=3, twi=2; in stage 2, j=3 SHALL read a=3, b=7, twi=3, with o_rd_sel=0.
REQ-032 With N=8 and LAT=2, o_done SHALL pulse 33 cycles after the first READ cycle, with o_result_sel=1.
REQ-033 Pulling rst low mid-READ SHALL force every output to 0 immediately; after release, with no i_start, o_wr_en SHALL stay 0.
REQ-034 An i_start pulse during LOAD SHALL be ignored, and the load count SHALL be unaffected.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: FSM state type, default sizing constants and the bit-reversal
// helper shared by the FFT address controller and its testbench.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        DRAIN,
        DONE
    } fft_state_t;

    localparam int MAX_AW    = 10;
    localparam int DEF_N     = 8;
    localparam int DEF_LAT   = 2;
    localparam int DEF_LOG2N = $clog2(DEF_N);

    // Number of address bits (and of radix-2 stages) for an FFT of length n.
    function automatic int log2n(input int n);
        return $clog2(n);
    endfunction

    // Width of the stage counter for an FFT of length n.
    function automatic int stage_w(input int n);
        return $clog2($clog2(n));
    endfunction

    // Reverse the low 'bits' bits of value; upper bits of the result are zero.
    function automatic logic [MAX_AW-1:0] bitrev(input logic [MAX_AW-1:0] value, input int bits);
        logic [MAX_AW-1:0] rev;
        for (int i = 0; i < MAX_AW; i++) begin
            rev[i] = value[MAX_AW-1-i];
        end
        return rev >> (MAX_AW - bits);
    endfunction

endpackage

// File: rtl/fft_ctrl_if.sv
// fft_ctrl_if: sample-load handshake plus the RAM read and write-back buses
// between the FFT controller (master) and the butterfly datapath (slave).
interface fft_ctrl_if
    import fft_pkg::*;
#(
    parameter int N = DEF_N
);
    localparam int AW = log2n(N);

    logic          i_load_valid;
    logic          o_load_ready;
    logic          o_load_wr_en;
    logic [AW-1:0] o_load_addr;

    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic          o_rd_odd;
    logic          o_rd_sel;
    logic [AW-2:0] o_twi_addr;

    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic          o_wr_bot;

    modport master (
        input  i_load_valid,
        output o_load_ready, o_load_wr_en, o_load_addr,
        output o_rd_en, o_rd_addr, o_rd_odd, o_rd_sel, o_twi_addr,
        output o_wr_en, o_wr_addr, o_wr_bot
    );

    modport slave (
        output i_load_valid,
        input  o_load_ready, o_load_wr_en, o_load_addr,
        input  o_rd_en, o_rd_addr, o_rd_odd, o_rd_sel, o_twi_addr,
        input  o_wr_en, o_wr_addr, o_wr_bot
    );

endinterface

// File: rtl/fft_wb_delay.sv
// fft_wb_delay: LAT+1-deep shift line carrying {valid, addr, bot} from the
// read side of a butterfly to its write-back, matching the datapath latency.
module fft_wb_delay
    import fft_pkg::*;
#(
    parameter int AW  = DEF_LOG2N,
    parameter int LAT = DEF_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic          in_bot,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic          out_bot
);
    localparam int DEPTH = LAT + 1;
    localparam int W     = AW + 2;

    logic [W-1:0] pipe [DEPTH];

    // Shift each read strobe down the line; reset empties it so no stale write can escape.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= {in_valid, in_addr, in_bot};
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign {out_valid, out_addr, out_bot} = pipe[DEPTH-1];

endmodule

// File: rtl/fft_ctrl.sv
// fft_ctrl: in-place radix-2 FFT address controller. Loads N samples at
// bit-reversed addresses, then sweeps log2(N) stages of butterflies,
// ping-ponging between RAM1 and RAM2.
// Optional feature macro: FFT_CTRL_INVERSE_EN adds i_inverse / o_twi_conj.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int LAT = DEF_LAT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    fft_ctrl_if.master                   bus,
    output logic [$clog2($clog2(N))-1:0] o_stage,
    output logic                         o_busy,
    output logic                         o_done,
`ifdef FFT_CTRL_INVERSE_EN
    output logic                         o_result_sel,
    input  logic                         i_inverse,
    output logic                         o_twi_conj
`else
    output logic                         o_result_sel
`endif
);
    localparam int AW      = log2n(N);
    localparam int LOG2N   = AW;
    localparam int STAGE_W = stage_w(N);
    localparam int TW      = AW - 1;

    fft_state_t    state;
    logic [AW-1:0] load_cnt;
    logic [AW-1:0] rd_cnt;
    logic [3:0]    drain_cnt;

    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic          wb_bot;

    // Read address for sequence index idx (two reads per butterfly) of stage s.
    function automatic logic [AW-1:0] rd_addr_of(input logic [AW-1:0] idx, input logic [STAGE_W-1:0] s);
        logic [AW-1:0] j;
        logic [AW-1:0] half;
        logic [AW-1:0] pos;
        logic [AW-1:0] a;
        j    = idx >> 1;
        half = AW'(1) << s;
        pos  = j & (half - AW'(1));
        a    = ((j >> s) << (s + 1)) + pos;
        return idx[0] ? a + half : a;
    endfunction

    // Twiddle ROM index for the butterfly owning sequence index idx in stage s.
    function automatic logic [TW-1:0] twi_of(input logic [AW-1:0] idx, input logic [STAGE_W-1:0] s);
        logic [AW-1:0] j;
        logic [AW-1:0] pos;
        j   = idx >> 1;
        pos = j & ((AW'(1) << s) - AW'(1));
        return TW'(pos << (LOG2N - 1 - int'(s)));
    endfunction

    // Run sequencer: walks IDLE/LOAD/READ/DRAIN/DONE and registers every control output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            load_cnt         <= '0;
            rd_cnt           <= '0;
            drain_cnt        <= '0;
            bus.o_load_ready <= 1'b0;
            bus.o_rd_en      <= 1'b0;
            bus.o_rd_addr    <= '0;
            bus.o_rd_odd     <= 1'b0;
            bus.o_rd_sel     <= 1'b0;
            bus.o_twi_addr   <= '0;
            o_stage          <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_result_sel     <= 1'b0;
`ifdef FFT_CTRL_INVERSE_EN
            o_twi_conj       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state            <= LOAD;
                        load_cnt         <= '0;
                        bus.o_load_ready <= 1'b1;
                        o_busy           <= 1'b1;
                        o_result_sel     <= 1'b0;
`ifdef FFT_CTRL_INVERSE_EN
                        o_twi_conj       <= i_inverse;
`endif
                    end
                end
                LOAD: begin
                    if (bus.i_load_valid) begin
                        if (load_cnt == AW'(N - 1)) begin
                            state            <= READ;
                            load_cnt         <= '0;
                            bus.o_load_ready <= 1'b0;
                            rd_cnt           <= '0;
                            o_stage          <= '0;
                            bus.o_rd_en      <= 1'b1;
                            bus.o_rd_addr    <= '0;
                            bus.o_rd_odd     <= 1'b0;
                            bus.o_twi_addr   <= '0;
                            bus.o_rd_sel     <= 1'b0;
                        end else begin
                            load_cnt <= load_cnt + AW'(1);
                        end
                    end
                end
                READ: begin
                    if (rd_cnt == AW'(N - 1)) begin
                        state          <= DRAIN;
                        drain_cnt      <= '0;
                        bus.o_rd_en    <= 1'b0;
                        bus.o_rd_addr  <= '0;
                        bus.o_rd_odd   <= 1'b0;
                        bus.o_twi_addr <= '0;
                    end else begin
                        rd_cnt         <= rd_cnt + AW'(1);
                        bus.o_rd_addr  <= rd_addr_of(rd_cnt + AW'(1), o_stage);
                        bus.o_rd_odd   <= ~rd_cnt[0];
                        bus.o_twi_addr <= twi_of(rd_cnt + AW'(1), o_stage);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 4'(LAT)) begin
                        if (o_stage == STAGE_W'(LOG2N - 1)) begin
                            state        <= DONE;
                            o_done       <= 1'b1;
                            o_result_sel <= 1'(LOG2N % 2);
                        end else begin
                            state          <= READ;
                            o_stage        <= o_stage + STAGE_W'(1);
                            bus.o_rd_sel   <= ~o_stage[0];
                            rd_cnt         <= '0;
                            bus.o_rd_en    <= 1'b1;
                            bus.o_rd_addr  <= '0;
                            bus.o_rd_odd   <= 1'b0;
                            bus.o_twi_addr <= '0;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 4'(1);
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    o_done       <= 1'b0;
                    o_busy       <= 1'b0;
                    o_stage      <= '0;
                    bus.o_rd_sel <= 1'b0;
`ifdef FFT_CTRL_INVERSE_EN
                    o_twi_conj   <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_load_wr_en = bus.o_load_ready & bus.i_load_valid;
    assign bus.o_load_addr  = AW'(bitrev(MAX_AW'(load_cnt), LOG2N));

    fft_wb_delay #(
        .AW  (AW),
        .LAT (LAT)
    ) u_wb_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.o_rd_en),
        .in_addr   (bus.o_rd_addr),
        .in_bot    (bus.o_rd_odd),
        .out_valid (wb_valid),
        .out_addr  (wb_addr),
        .out_bot   (wb_bot)
    );

    assign bus.o_wr_en   = wb_valid;
    assign bus.o_wr_addr = wb_addr;
    assign bus.o_wr_bot  = wb_bot;

endmodule
